// File: rtl/xadac_pkg.sv
// Shared types and default widths for the XADAC execute-slot units.
package xadac_pkg;

    localparam int unsigned SumWidth = 16;
    localparam int unsigned IdWidth  = 4;

    typedef logic signed [SumWidth-1:0] SumT;

    typedef enum logic [1:0] {
        VB_BCAST = 2'd0,
        VB_ADD   = 2'd1,
        VB_LOAD  = 2'd2,
        VB_APPLY = 2'd3
    } vbias_mode_e;

endpackage

// File: rtl/xadac_vbias_pipe_if.sv
// Request/response handshake bundle between the dispatcher and the vector-bias unit.
interface xadac_vbias_pipe_if #(
    parameter int unsigned NumLanes = 8,
    parameter int unsigned SumWidth = xadac_pkg::SumWidth,
    parameter int unsigned IdWidth  = xadac_pkg::IdWidth,
    parameter int unsigned ImmWidth = 8
) ();
    import xadac_pkg::*;

    localparam int unsigned VLEN = NumLanes * SumWidth;

    logic                req_valid;
    logic                req_ready;
    logic [IdWidth-1:0]  req_id;
    vbias_mode_e         req_mode;
    logic [31:0]         req_rs1;
    logic [ImmWidth-1:0] req_imm;
    logic [VLEN-1:0]     req_vs1;

    logic                resp_valid;
    logic                resp_ready;
    logic [IdWidth-1:0]  resp_id;
    logic [31:0]         resp_rd;
    logic [VLEN-1:0]     resp_vd;

    modport master (
        output req_valid, req_id, req_mode, req_rs1, req_imm, req_vs1, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_rd, resp_vd
    );

    modport slave (
        input  req_valid, req_id, req_mode, req_rs1, req_imm, req_vs1, resp_ready,
        output req_ready, resp_valid, resp_id, resp_rd, resp_vd
    );

endinterface

// File: rtl/xadac_sat_add.sv
// One signed lane adder; clamps to the lane range when Saturate is nonzero, else wraps.
module xadac_sat_add #(
    parameter int unsigned SumWidth = xadac_pkg::SumWidth,
    parameter int unsigned Saturate = 1
) (
    input  logic signed [SumWidth-1:0] i_a,
    input  logic signed [SumWidth-1:0] i_b,
    output logic signed [SumWidth-1:0] o_sum_c
);

    logic signed [SumWidth:0] w_full;
    logic                     w_ovf;

    // One extra bit of headroom exposes overflow as a sign/carry disagreement.
    always_comb begin
        w_full  = {i_a[SumWidth-1], i_a} + {i_b[SumWidth-1], i_b};
        w_ovf   = w_full[SumWidth] ^ w_full[SumWidth-1];
        o_sum_c = w_full[SumWidth-1:0];
        if ((Saturate != 0) && w_ovf) begin
            o_sum_c = w_full[SumWidth] ? {1'b1, {(SumWidth-1){1'b0}}}
                                       : {1'b0, {(SumWidth-1){1'b1}}};
        end
    end

endmodule

// File: rtl/xadac_vbias_pipe.sv
// Vector-bias execute unit: broadcast/add scalar bias, load/apply a per-lane bias table,
// with a single registered response stage and full-throughput valid/ready handshaking.
module xadac_vbias_pipe
    import xadac_pkg::*;
#(
    parameter int unsigned NumLanes = 8,
    parameter int unsigned SumWidth = xadac_pkg::SumWidth,
    parameter int unsigned IdWidth  = xadac_pkg::IdWidth,
    parameter int unsigned ImmWidth = 8,
    parameter int unsigned Saturate = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    xadac_vbias_pipe_if.slave  bus
);

    localparam int unsigned VLEN = NumLanes * SumWidth;
    localparam int unsigned IdxW = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam logic signed [31:0] BiasMax = 32'((64'(1) << (SumWidth - 1)) - 64'(1));
    localparam logic signed [31:0] BiasMin = ~BiasMax;

    logic signed [SumWidth-1:0] r_bias [NumLanes];
    logic                       r_resp_valid;
    logic [IdWidth-1:0]         r_resp_id;
    logic [31:0]                r_resp_rd;
    logic [VLEN-1:0]            r_resp_vd;

    logic                       w_accept;
    logic                       w_load_hit;
    logic [IdxW-1:0]            w_idx;
    logic signed [SumWidth-1:0] w_bias;
    logic signed [SumWidth-1:0] w_vs1    [NumLanes];
    logic signed [SumWidth-1:0] w_addend [NumLanes];
    logic signed [SumWidth-1:0] w_sum    [NumLanes];
    logic [31:0]                w_rd;
    logic [VLEN-1:0]            w_vd;

    assign bus.req_ready = !r_resp_valid || bus.resp_ready;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_load_hit    = (bus.req_mode == VB_LOAD) && (32'(bus.req_imm) < NumLanes);
    assign w_idx         = IdxW'(bus.req_imm);

    // Narrow the 32-bit scalar operand into one lane.
    always_comb begin
        w_bias = SumWidth'(bus.req_rs1);
        if (Saturate != 0) begin
            if ($signed(bus.req_rs1) > BiasMax) begin
                w_bias = SumWidth'(BiasMax);
            end else if ($signed(bus.req_rs1) < BiasMin) begin
                w_bias = SumWidth'(BiasMin);
            end
        end
    end

    // The same adders serve ADD (scalar addend) and APPLY (table addend).
    for (genvar g = 0; g < NumLanes; g++) begin : g_lane
        assign w_vs1[g]    = bus.req_vs1[g*SumWidth +: SumWidth];
        assign w_addend[g] = (bus.req_mode == VB_APPLY) ? r_bias[g] : w_bias;

        xadac_sat_add #(
            .SumWidth (SumWidth),
            .Saturate (Saturate)
        ) u_add (
            .i_a     (w_vs1[g]),
            .i_b     (w_addend[g]),
            .o_sum_c (w_sum[g])
        );
    end

    always_comb begin
        w_rd = '0;
        w_vd = '0;
        case (bus.req_mode)
            VB_BCAST: begin
                for (int unsigned i = 0; i < NumLanes; i++) begin
                    if (i < 32'(bus.req_imm)) begin
                        w_vd[i*SumWidth +: SumWidth] = w_bias;
                    end
                end
            end
            VB_ADD: begin
                for (int unsigned i = 0; i < NumLanes; i++) begin
                    w_vd[i*SumWidth +: SumWidth] = (i < 32'(bus.req_imm)) ? w_sum[i] : w_vs1[i];
                end
            end
            VB_LOAD: begin
                if (w_load_hit) begin
                    w_rd = 32'(r_bias[w_idx]);
                end
            end
            VB_APPLY: begin
                for (int unsigned i = 0; i < NumLanes; i++) begin
                    w_vd[i*SumWidth +: SumWidth] = w_sum[i];
                end
            end
            default: ;
        endcase
    end

    // Response stage and bias table both advance only on an accepting edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_rd    <= '0;
            r_resp_vd    <= '0;
            for (int unsigned i = 0; i < NumLanes; i++) begin
                r_bias[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= bus.req_id;
                r_resp_rd    <= w_rd;
                r_resp_vd    <= w_vd;
                if (w_load_hit) begin
                    r_bias[w_idx] <= w_bias;
                end
            end else if (bus.resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_rd    = r_resp_rd;
    assign bus.resp_vd    = r_resp_vd;

endmodule

// File: tb/tb_xadac_vbias_pipe.sv
// Bench for xadac_vbias_pipe: directed vector table, backpressure/reset sequences, random scoreboard run.
module tb_xadac_vbias_pipe;
    import xadac_pkg::*;

    localparam int unsigned NL = 8;
    localparam int unsigned SW = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned MW = 8;

    typedef struct {
        logic [1:0]   mode;
        logic [31:0]  rs1;
        logic [7:0]   imm;
        logic [127:0] vs1;
        logic [31:0]  exp_rd;
        logic [127:0] exp_vd;
    } vec_t;

    typedef struct {
        logic [3:0]   id;
        logic [31:0]  rd;
        logic [127:0] vd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xadac_vbias_pipe_if #(.NumLanes(NL), .SumWidth(SW), .IdWidth(IW), .ImmWidth(MW)) bus ();

    xadac_vbias_pipe #(
        .NumLanes (NL),
        .SumWidth (SW),
        .IdWidth  (IW),
        .ImmWidth (MW),
        .Saturate (1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t       sb_q[$];
    vec_t       tv[13];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         stalls   = 0;
    int         model_bias[8];
    logic [3:0] next_id  = '0;
    bit         rand_rr  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input logic [31:0] rs1, input logic [7:0] imm,
                                input logic [127:0] vs1, input logic [31:0] erd, input logic [127:0] evd);
        vec_t v;
        v.mode = mode; v.rs1 = rs1; v.imm = imm; v.vs1 = vs1; v.exp_rd = erd; v.exp_vd = evd;
        return v;
    endfunction

    function automatic logic [127:0] rep(input logic [15:0] x);
        return {8{x}};
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // Reference behaviour, evaluated in request order with its own copy of the table.
    function automatic void model(input logic [1:0] mode, input logic [31:0] rs1, input logic [7:0] imm,
                                  input logic [127:0] vs1, output logic [31:0] rd, output logic [127:0] vd);
        int b;
        int a;
        b  = clamp16(longint'($signed(rs1)));
        rd = '0;
        vd = '0;
        for (int l = 0; l < 8; l++) begin
            a = int'($signed(vs1[l*16 +: 16]));
            case (mode)
                2'd0: if (l < int'(imm)) vd[l*16 +: 16] = 16'(b);
                2'd1: vd[l*16 +: 16] = (l < int'(imm)) ? 16'(clamp16(longint'(a + b))) : 16'(a);
                2'd3: vd[l*16 +: 16] = 16'(clamp16(longint'(a + model_bias[l])));
                default: ;
            endcase
        end
        if (mode == 2'd2 && int'(imm) < 8) begin
            rd = 32'(model_bias[int'(imm)]);
            model_bias[int'(imm)] = b;
        end
    endfunction

    task automatic send(input logic [1:0] mode, input logic [31:0] rs1, input logic [7:0] imm,
                        input logic [127:0] vs1, input logic [31:0] erd, input logic [127:0] evd);
        exp_t e;
        int   waited;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_mode  = vbias_mode_e'(mode);
        bus.req_rs1   = rs1;
        bus.req_imm   = imm;
        bus.req_vs1   = vs1;
        bus.req_id    = next_id;
        e.id = next_id; e.rd = erd; e.vd = evd;
        next_id++;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready) begin
            waited++;
            if (waited > 500) begin
                $display("FAIL send_timeout: got no req_ready want req_ready within 500 cycles");
                $fatal(1, "request never accepted");
            end
            @(negedge clk);
        end
        if (waited != 0) stalls++;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Scoreboard: every accepted response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else if (bus.resp_valid && bus.resp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got id %0d want no response", bus.resp_id);
            end else begin
                e = sb_q.pop_front();
                check("resp_id", 128'(bus.resp_id), 128'(e.id));
                check("resp_rd", 128'(bus.resp_rd), 128'(e.rd));
                check("resp_vd", bus.resp_vd, e.vd);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rr) begin
            #1 bus.resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        exp_t       ea;
        exp_t       eb;
        logic [31:0]  rs1;
        logic [7:0]   imm;
        logic [127:0] vs1;
        logic [31:0]  erd;
        logic [127:0] evd;
        logic [1:0]   mode;

        bus.req_valid  = 1'b0;
        bus.req_id     = '0;
        bus.req_mode   = VB_BCAST;
        bus.req_rs1    = '0;
        bus.req_imm    = '0;
        bus.req_vs1    = '0;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) model_bias[i] = 0;

        tv[0]  = mk(2'd0, 32'd5, 8'd3, 128'h0, 32'h0, {80'h0, 16'd5, 16'd5, 16'd5});
        tv[1]  = mk(2'd1, 32'h100, 8'd8, rep(16'h7FF0), 32'h0, rep(16'h7FFF));
        tv[2]  = mk(2'd0, 32'hFFFE_EE90, 8'd1, 128'h0, 32'h0, {112'h0, 16'h8000});
        tv[3]  = mk(2'd1, 32'hFFFF_FFFF, 8'd4,
                    {16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h3000, 16'h2000, 16'h1000, 16'h0000}, 32'h0,
                    {16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h2FFF, 16'h1FFF, 16'h0FFF, 16'hFFFF});
        tv[4]  = mk(2'd2, 32'd7, 8'd2, 128'h0, 32'h0, 128'h0);
        tv[5]  = mk(2'd2, 32'd9, 8'd2, 128'h0, 32'd7, 128'h0);
        tv[6]  = mk(2'd3, 32'd0, 8'd0, 128'h0, 32'h0, {80'h0, 16'h0009, 16'h0, 16'h0});
        tv[7]  = mk(2'd2, 32'd123, 8'd8, 128'h0, 32'h0, 128'h0);
        tv[8]  = mk(2'd2, 32'hFFFF_FFFD, 8'd5, 128'h0, 32'h0, 128'h0);
        tv[9]  = mk(2'd2, 32'd100000, 8'd5, 128'h0, 32'hFFFF_FFFD, 128'h0);
        tv[10] = mk(2'd3, 32'd0, 8'd0, rep(16'h7FF0), 32'h0,
                    {16'h7FF0, 16'h7FF0, 16'h7FFF, 16'h7FF0, 16'h7FF0, 16'h7FF9, 16'h7FF0, 16'h7FF0});
        tv[11] = mk(2'd1, 32'hFFFF_FF00, 8'd200, rep(16'h8010), 32'h0, rep(16'h8000));
        tv[12] = mk(2'd0, 32'd5, 8'd0, rep(16'h1234), 32'h0, 128'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 128'(bus.resp_valid), 128'(0));
        check("rst_id", 128'(bus.resp_id), 128'(0));
        check("rst_rd", 128'(bus.resp_rd), 128'(0));
        check("rst_vd", bus.resp_vd, 128'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First transaction alone to pin down the one-cycle latency.
        send(tv[0].mode, tv[0].rs1, tv[0].imm, tv[0].vs1, tv[0].exp_rd, tv[0].exp_vd);
        idle();
        @(negedge clk);
        check("lat_valid", 128'(bus.resp_valid), 128'(1));
        check("lat_id", 128'(bus.resp_id), 128'(0));

        stalls = 0;
        for (int i = 1; i < 13; i++) begin
            send(tv[i].mode, tv[i].rs1, tv[i].imm, tv[i].vs1, tv[i].exp_rd, tv[i].exp_vd);
        end
        idle();
        check("b2b_stalls", 128'(stalls), 128'(0));
        repeat (3) @(negedge clk);
        check("table_drain", 128'(sb_q.size()), 128'(0));

        // Backpressure: one response held, one request waiting behind it.
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        ea.id = next_id;      ea.vd = rep(16'h1234);
        eb.id = next_id + 1;  eb.vd = {96'h0, 16'h0042, 16'h0042};
        send(2'd0, 32'h1234, 8'd8, 128'h0, 32'h0, ea.vd);
        fork
            send(2'd0, 32'h42, 8'd2, 128'h0, 32'h0, eb.vd);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_req_ready", 128'(bus.req_ready), 128'(0));
                    check("bp_valid", 128'(bus.resp_valid), 128'(1));
                    check("bp_id", 128'(bus.resp_id), 128'(ea.id));
                    check("bp_vd", bus.resp_vd, ea.vd);
                end
                @(posedge clk); #1;
                bus.resp_ready = 1'b1;
            end
        join
        idle();
        @(negedge clk);
        check("bp_second_valid", 128'(bus.resp_valid), 128'(1));
        check("bp_second_id", 128'(bus.resp_id), 128'(eb.id));

        // Reset while a response is held, then confirm the table was cleared.
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        send(2'd0, 32'd1, 8'd8, 128'h0, 32'h0, rep(16'h0001));
        idle();
        @(negedge clk);
        check("pre_rst_valid", 128'(bus.resp_valid), 128'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 128'(bus.resp_valid), 128'(0));
        send(2'd3, 32'd0, 8'd0, 128'h0, 32'h0, 128'h0);
        idle();
        repeat (2) @(negedge clk);
        check("post_rst_drain", 128'(sb_q.size()), 128'(0));

        // Random traffic against the reference model with random response backpressure.
        rand_rr = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 4) == 0) idle();
            mode = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       rs1 = 32'($urandom_range(0, 200)) - 32'd100;
                1:       rs1 = $urandom;
                default: rs1 = {{16{1'b0}}, 16'($urandom)};
            endcase
            imm = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 10));
            vs1 = {$urandom, $urandom, $urandom, $urandom};
            model(mode, rs1, imm, vs1, erd, evd);
            send(mode, rs1, imm, vs1, erd, evd);
        end
        idle();
        rand_rr = 1'b0;
        @(posedge clk); #2;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        check("final_drain", 128'(sb_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
